// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoding constants for the MIPS program loader and the control decoder.
package instr_encoder_loader_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpSlt  = 4'd4,
        OpAddi = 4'd5,
        OpAndi = 4'd6,
        OpOri  = 4'd7,
        OpSlti = 4'd8,
        OpLw   = 4'd9,
        OpSw   = 4'd10,
        OpBeq  = 4'd11,
        OpBne  = 4'd12,
        OpJ    = 4'd13
    } op_e;

    localparam logic [5:0] OpcR    = 6'b000000;
    localparam logic [5:0] OpcAddi = 6'b001000;
    localparam logic [5:0] OpcAndi = 6'b001100;
    localparam logic [5:0] OpcOri  = 6'b001101;
    localparam logic [5:0] OpcSlti = 6'b001010;
    localparam logic [5:0] OpcLw   = 6'b100011;
    localparam logic [5:0] OpcSw   = 6'b101011;
    localparam logic [5:0] OpcBeq  = 6'b000100;
    localparam logic [5:0] OpcBne  = 6'b000101;
    localparam logic [5:0] OpcJ    = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational packer: symbolic op plus fields to a 32-bit MIPS word.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OpcR, rs, rt, rd, 5'b00000, fn};
    endfunction

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_e'(op_i))
            OpAdd:   word_o = rtype(rs_i, rt_i, rd_i, FnAdd);
            OpSub:   word_o = rtype(rs_i, rt_i, rd_i, FnSub);
            OpAnd:   word_o = rtype(rs_i, rt_i, rd_i, FnAnd);
            OpOr:    word_o = rtype(rs_i, rt_i, rd_i, FnOr);
            OpSlt:   word_o = rtype(rs_i, rt_i, rd_i, FnSlt);
            OpAddi:  word_o = {OpcAddi, rs_i, rt_i, imm_i};
            OpAndi:  word_o = {OpcAndi, rs_i, rt_i, imm_i};
            OpOri:   word_o = {OpcOri, rs_i, rt_i, imm_i};
            OpSlti:  word_o = {OpcSlti, rs_i, rt_i, imm_i};
            OpLw:    word_o = {OpcLw, rs_i, rt_i, imm_i};
            OpSw:    word_o = {OpcSw, rs_i, rt_i, imm_i};
            OpBeq:   word_o = {OpcBeq, rs_i, rt_i, imm_i};
            OpBne:   word_o = {OpcBne, rs_i, rt_i, imm_i};
            OpJ:     word_o = {OpcJ, target_i};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes handshaked instruction requests and writes them to
// instruction memory at consecutive word addresses.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    state_e            state_q;
    logic   [ADDR_W:0] count_q;
    logic              err_q;
    logic   [31:0]     pk_word;
    logic              pk_illegal;
    logic              xfer;

    instr_field_packer u_packer (
        .op_i      (in_op),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .imm_i     (in_imm),
        .target_i  (in_target),
        .word_o    (pk_word),
        .illegal_o (pk_illegal)
    );

    assign full       = (count_q == DepthCnt);
    assign in_ready   = (state_q == StLoad) && !full;
    assign xfer       = in_valid && in_ready;
    assign busy       = (state_q == StLoad);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign word_count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            err_q      <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BaseAddr;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            // Illegal ops complete the handshake but leave memory and count untouched.
            if (xfer) begin
                if (pk_illegal) begin
                    err_q <= 1'b1;
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= BaseAddr + count_q[ADDR_W-1:0];
                    imem_wdata <= pk_word;
                    count_q    <= count_q + 1'b1;
                end
            end
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StLoad;
                        count_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                StLoad: begin
                    if (finish) state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader, built with DEPTH=4 to reach the full boundary.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset, start, finish, in_valid;
    logic        in_ready, imem_we, busy, done, full, err;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  word_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] exp;
    } vec_t;

    vec_t tab[14];

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .finish     (finish),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_op     = v.op;
        in_rs     = v.rs;
        in_rt     = v.rt;
        in_rd     = v.rd;
        in_imm    = v.imm;
        in_target = v.target;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_we"}, 32'(imem_we), 32'd0);
        check_eq({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check_eq({tag, "_wdata"}, imem_wdata, 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_full"}, 32'(full), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_count"}, 32'(word_count), 32'd0);
    endtask

    // Loads n table entries back to back, asserting finish with the last one.
    task automatic run_load(input int first, input int n);
        pulse_start();
        check_eq("load_busy", 32'(busy), 32'd1);
        check_eq("load_count0", 32'(word_count), 32'd0);
        for (int k = 0; k < n; k++) begin
            drive(tab[first+k]);
            finish = (k == n - 1);
            tick();
            check_eq($sformatf("enc_we_%0d", first + k), 32'(imem_we), 32'd1);
            check_eq($sformatf("enc_addr_%0d", first + k), 32'(imem_addr), 32'(k));
            check_eq($sformatf("enc_word_%0d", first + k), imem_wdata, tab[first+k].exp);
            check_eq($sformatf("enc_cnt_%0d", first + k), 32'(word_count), 32'(k + 1));
        end
        in_valid = 1'b0;
        finish   = 1'b0;
        check_eq("fin_done", 32'(done), 32'd1);
        check_eq("fin_ready", 32'(in_ready), 32'd0);
        tick();
        check_eq("fin_we_drop", 32'(imem_we), 32'd0);
        check_eq("fin_hold", imem_wdata, tab[first+n-1].exp);
    endtask

    initial begin
        tab[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h00221820};
        tab[1]  = '{4'd1,  5'd3,  5'd4,  5'd5,  16'hFFFF, 26'h3FFFFFF, 32'h00642822};
        tab[2]  = '{4'd2,  5'd7,  5'd8,  5'd9,  16'hFFFF, 26'h3FFFFFF, 32'h00E84824};
        tab[3]  = '{4'd3,  5'd4,  5'd5,  5'd6,  16'hFFFF, 26'h3FFFFFF, 32'h00853025};
        tab[4]  = '{4'd4,  5'd10, 5'd11, 5'd12, 16'hFFFF, 26'h3FFFFFF, 32'h014B602A};
        tab[5]  = '{4'd5,  5'd1,  5'd2,  5'd31, 16'h0005, 26'h3FFFFFF, 32'h20220005};
        tab[6]  = '{4'd6,  5'd1,  5'd2,  5'd31, 16'h00FF, 26'h3FFFFFF, 32'h302200FF};
        tab[7]  = '{4'd7,  5'd3,  5'd4,  5'd31, 16'h1234, 26'h3FFFFFF, 32'h34641234};
        tab[8]  = '{4'd8,  5'd5,  5'd6,  5'd31, 16'h8000, 26'h3FFFFFF, 32'h28A68000};
        tab[9]  = '{4'd9,  5'd29, 5'd8,  5'd31, 16'h0004, 26'h3FFFFFF, 32'h8FA80004};
        tab[10] = '{4'd10, 5'd29, 5'd9,  5'd31, 16'h0008, 26'h3FFFFFF, 32'hAFA90008};
        tab[11] = '{4'd11, 5'd1,  5'd2,  5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h1022FFFF};
        tab[12] = '{4'd12, 5'd2,  5'd3,  5'd31, 16'hFFFE, 26'h3FFFFFF, 32'h1443FFFE};
        tab[13] = '{4'd13, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 32'h08000010};

        reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("rst");

        // Input ignored before start; finish outside LOAD ignored.
        drive(tab[0]);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        in_valid = 1'b0;
        check_eq("idle_no_we", 32'(imem_we), 32'd0);
        check_eq("idle_no_done", 32'(done), 32'd0);

        // Single ADD.
        pulse_start();
        check_eq("start_ready", 32'(in_ready), 32'd1);
        drive(tab[0]);
        tick();
        in_valid = 1'b0;
        check_eq("add_we", 32'(imem_we), 32'd1);
        check_eq("add_addr", 32'(imem_addr), 32'd0);
        check_eq("add_word", imem_wdata, 32'h00221820);
        check_eq("add_cnt", 32'(word_count), 32'd1);
        tick();
        check_eq("add_we_pulse", 32'(imem_we), 32'd0);
        pulse_finish();
        check_eq("add_done", 32'(done), 32'd1);

        // Every op encoding, loads of up to four words.
        run_load(0, 4);
        run_load(4, 4);
        run_load(8, 4);
        run_load(12, 2);

        // Full boundary: ADDI, LW, BEQ, J then a fifth request that must stall.
        pulse_start();
        begin
            int idx[4] = '{5, 9, 11, 13};
            for (int k = 0; k < 4; k++) begin
                drive(tab[idx[k]]);
                tick();
                check_eq($sformatf("b2b_addr_%0d", k), 32'(imem_addr), 32'(k));
                check_eq($sformatf("b2b_word_%0d", k), imem_wdata, tab[idx[k]].exp);
            end
        end
        check_eq("full_flag", 32'(full), 32'd1);
        check_eq("full_ready", 32'(in_ready), 32'd0);
        drive(tab[0]);
        tick();
        check_eq("full_no_we", 32'(imem_we), 32'd0);
        check_eq("full_cnt", 32'(word_count), 32'd4);
        in_valid = 1'b0;
        pulse_finish();
        check_eq("full_done", 32'(done), 32'd1);

        // Illegal op between two legal ones.
        pulse_start();
        check_eq("restart_cnt", 32'(word_count), 32'd0);
        check_eq("restart_full", 32'(full), 32'd0);
        drive(tab[0]);
        tick();
        in_op = 4'd14;
        tick();
        check_eq("ill_no_we", 32'(imem_we), 32'd0);
        check_eq("ill_err", 32'(err), 32'd1);
        check_eq("ill_cnt", 32'(word_count), 32'd1);
        check_eq("ill_hold", imem_wdata, 32'h00221820);
        drive(tab[3]);
        tick();
        in_valid = 1'b0;
        check_eq("ill_next_addr", 32'(imem_addr), 32'd1);
        check_eq("ill_next_word", imem_wdata, 32'h00853025);
        check_eq("ill_next_cnt", 32'(word_count), 32'd2);
        pulse_start();
        check_eq("load_start_ignored", 32'(err), 32'd1);
        pulse_finish();
        pulse_start();
        check_eq("start_clears_err", 32'(err), 32'd0);

        // Reset the cycle after a transfer drops everything.
        drive(tab[5]);
        tick();
        in_valid = 1'b0;
        check_eq("pre_rst_we", 32'(imem_we), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("mid_rst");

        // Reset coincident with a request: nothing written.
        pulse_start();
        drive(tab[6]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        check_eq("rst_xfer_we", 32'(imem_we), 32'd0);
        check_eq("rst_xfer_cnt", 32'(word_count), 32'd0);
        check_eq("rst_xfer_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
